// File: rtl/mac_pipe.sv
// mac_pipe: pipelined multi-lane multiply/add/accumulate element with valid tags and sticky overflow.
// Define MAC_PIPE_SAT_EN for a saturating accumulator and clamped lane outputs.
module mac_pipe #(
  parameter int WW    = 4,
  parameter int NLANE = 2,
  parameter int PIPE  = 2,
  parameter int GUARD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cset,
  input  logic [1:0]              conf,
  input  logic [2*WW*NLANE-1:0]   inputs,
  input  logic [1:0]              control_inputs,
  output logic [2*WW*NLANE-1:0]   outputs,
  output logic                    valid_out,
  output logic [NLANE-1:0]        ovf
);
  localparam int OW   = 2*WW;
  localparam int ACCW = OW+GUARD;
  logic [1:0]      mode;
  logic [PIPE-1:0] vld, clr;
  logic [OW-1:0]   res [PIPE][NLANE];
  logic [OW-1:0]   op [NLANE];
  logic [ACCW-1:0] acc [NLANE];
  logic [ACCW-1:0] nxt [NLANE];
  logic [NLANE-1:0] novf;
  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    logic [OW-1:0] a, b;
    logic [ACCW:0] sum;
    assign a = OW'(inputs[2*WW*i +: WW]);
    assign b = OW'(inputs[2*WW*i+WW +: WW]);
    assign op[i] = mode == 2'b00 ? a : mode == 2'b11 ? a + b : a * b;
    assign sum = {1'b0, acc[i]} + (ACCW+1)'(res[PIPE-1][i]);
`ifdef MAC_PIPE_SAT_EN
    assign nxt[i]  = sum[ACCW] ? '1 : sum[ACCW-1:0];
    assign novf[i] = sum[ACCW] | (|nxt[i][ACCW-1:OW]);
    assign outputs[OW*i +: OW] = |acc[i][ACCW-1:OW] ? '1 : acc[i][OW-1:0];
`else
    assign nxt[i]  = sum[ACCW-1:0];
    assign novf[i] = sum[ACCW];
    assign outputs[OW*i +: OW] = acc[i][OW-1:0];
`endif
  end
  always_ff @(posedge clk) begin
    for (int l = 0; l < NLANE; l++) res[0][l] <= op[l];
    for (int s = 1; s < PIPE; s++)
      for (int l = 0; l < NLANE; l++) res[s][l] <= res[s-1][l];
  end
  always_ff @(posedge clk) begin
    if (rst) mode <= 2'b00;
    else if (cset) mode <= conf;
    if (rst || cset) begin
      vld       <= '0;
      clr       <= '0;
      valid_out <= 1'b0;
      ovf       <= '0;
      for (int l = 0; l < NLANE; l++) acc[l] <= '0;
    end else begin
      vld[0] <= control_inputs[0];
      clr[0] <= control_inputs[1];
      for (int s = 1; s < PIPE; s++) begin
        vld[s] <= vld[s-1];
        clr[s] <= clr[s-1];
      end
      valid_out <= vld[PIPE-1];
      for (int l = 0; l < NLANE; l++) begin
        if (vld[PIPE-1]) begin
          // a cleared MAC restarts from the product, which is the stage result in this mode
          if (mode == 2'b10 && !clr[PIPE-1]) begin
            acc[l] <= nxt[l];
            ovf[l] <= ovf[l] | novf[l];
          end else begin
            acc[l] <= ACCW'(res[PIPE-1][l]);
            if (clr[PIPE-1]) ovf[l] <= 1'b0;
          end
        end else if (clr[PIPE-1]) begin
          acc[l] <= '0;
          ovf[l] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_pipe.sv
// tb_mac_pipe: directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_mac_pipe;
  localparam int WW = 4, NLANE = 2, PIPE = 2, GUARD = 4;
  localparam int ACCMAX = 4095;
  logic clk = 0, rst = 0, cset = 0, vin = 0, clr = 0;
  logic [1:0] conf = 0;
  logic [3:0] a [2] = '{0, 0};
  logic [3:0] b [2] = '{0, 0};
  logic [15:0] inputs, outputs;
  logic [1:0] ctl, ovf;
  logic valid_out;
  int checks = 0, failures = 0;
  assign inputs = {b[1], a[1], b[0], a[0]};
  assign ctl = {clr, vin};
  always #5 clk = ~clk;
  mac_pipe #(.WW(WW), .NLANE(NLANE), .PIPE(PIPE), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .cset(cset), .conf(conf), .inputs(inputs),
    .control_inputs(ctl), .outputs(outputs), .valid_out(valid_out), .ovf(ovf));
  typedef struct packed {logic v; logic c; logic [15:0] d;} ent_t;
  ent_t q [$];
  ent_t e;
  int m_acc [2] = '{0, 0};
  bit m_ovf [2] = '{0, 0};
  bit m_valid = 0;
  logic [1:0] m_mode = 0;
  function automatic int m_out(int l);
`ifdef MAC_PIPE_SAT_EN
    return m_acc[l] > 255 ? 255 : m_acc[l];
`else
    return m_acc[l] % 256;
`endif
  endfunction
  // Samples enter a queue PIPE entries deep and are applied to the lane state when they leave it.
  always @(posedge clk) begin
    if (rst || cset) begin
      q.delete();
      for (int i = 0; i < PIPE; i++) q.push_back('0);
      m_acc = '{0, 0};
      m_ovf = '{0, 0};
      m_valid = 0;
      m_mode = rst ? 2'b00 : conf;
    end else begin
      e = q.size() != 0 ? q.pop_front() : '0;
      m_valid = e.v;
      for (int l = 0; l < 2; l++) begin
        int x, y, s, r;
        x = int'(e.d[8*l +: 4]);
        y = int'(e.d[8*l+4 +: 4]);
        r = m_mode == 2'b00 ? x : m_mode == 2'b11 ? x + y : x * y;
        if (e.v && m_mode == 2'b10 && !e.c) begin
          s = m_acc[l] + x * y;
          if (s > ACCMAX) begin
            m_ovf[l] = 1;
`ifdef MAC_PIPE_SAT_EN
            s = ACCMAX;
`else
            s = s - (ACCMAX + 1);
`endif
          end
          m_acc[l] = s;
`ifdef MAC_PIPE_SAT_EN
          if (s > 255) m_ovf[l] = 1;
`endif
        end else if (e.v) begin
          m_acc[l] = r;
          if (e.c) m_ovf[l] = 0;
        end else if (e.c) begin
          m_acc[l] = 0;
          m_ovf[l] = 0;
        end
      end
      q.push_back(ent_t'({vin, clr, inputs}));
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic cfg(input logic [1:0] m);
    cset = 1; conf = m; vin = 0; clr = 0;
    tick();
    cset = 0;
  endtask
  task automatic test_reset();
    rst = 1; vin = 1'($urandom); clr = 1'($urandom);
    a[0] = 4'($urandom); b[0] = 4'($urandom); a[1] = 4'($urandom); b[1] = 4'($urandom);
    tick(); tick();
    rst = 0; vin = 0; clr = 0;
    checks++; if (outputs !== 16'h0) begin failures++; $display("FAIL reset_outputs got=%h exp=0000", outputs); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (ovf !== 2'b00) begin failures++; $display("FAIL reset_ovf got=%b exp=00", ovf); end
    a[0] = 9; vin = 1;
    tick();
    vin = 0;
    tick();
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL bypass_early_valid got=%b exp=0", valid_out); end
    tick();
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%b exp=1", valid_out); end
    checks++; if (outputs[7:0] !== 8'd9) begin failures++; $display("FAIL bypass_lane0 got=%0d exp=9", outputs[7:0]); end
  endtask
  task automatic test_multiply();
    cfg(2'b01);
    a[0] = 15; b[0] = 15; a[1] = 3; b[1] = 7; vin = 1;
    tick();
    vin = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (valid_out !== (k == 1)) begin failures++; $display("FAIL mul_valid_pulse k=%0d got=%b exp=%b", k, valid_out, k == 1); end
      if (k >= 1) begin
        checks++; if (outputs !== {8'd21, 8'd225}) begin failures++; $display("FAIL mul_result got=%0d/%0d exp=225/21", outputs[7:0], outputs[15:8]); end
      end
    end
  endtask
  task automatic test_mac_stream();
    int sa [4] = '{3, 5, 0, 2};
    int sb [4] = '{4, 5, 0, 2};
    bit sv [4] = '{1, 1, 0, 1};
    bit sc [4] = '{1, 0, 0, 0};
    int eo [4] = '{12, 37, 37, 41};
    cfg(2'b10);
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        a[0] = 4'(sa[k]); b[0] = 4'(sb[k]); a[1] = 4'($urandom); b[1] = 4'($urandom);
        vin = sv[k]; clr = sc[k];
      end else begin
        vin = 0; clr = 0;
      end
      tick();
      if (k >= 2) begin
        checks++; if (outputs[7:0] !== 8'(eo[k-2])) begin failures++; $display("FAIL mac_stream_lane0 step=%0d got=%0d exp=%0d", k-2, outputs[7:0], eo[k-2]); end
        checks++; if (valid_out !== sv[k-2]) begin failures++; $display("FAIL mac_stream_valid step=%0d got=%b exp=%b", k-2, valid_out, sv[k-2]); end
        checks++; if (outputs[15:8] !== 8'(m_out(1))) begin failures++; $display("FAIL mac_stream_lane1 step=%0d got=%0d exp=%0d", k-2, outputs[15:8], m_out(1)); end
      end
    end
  endtask
  task automatic test_overflow();
    int exp0;
`ifdef MAC_PIPE_SAT_EN
    exp0 = 255;
`else
    exp0 = 179;
`endif
    cfg(2'b10);
    for (int k = 0; k < 19; k++) begin
      a[0] = 15; b[0] = 15; a[1] = 1; b[1] = 1; vin = 1; clr = (k == 0);
      tick();
    end
    vin = 0; clr = 0;
    tick(); tick();
    checks++; if (outputs[7:0] !== 8'(exp0)) begin failures++; $display("FAIL ovf_lane0 got=%0d exp=%0d", outputs[7:0], exp0); end
    checks++; if (outputs[15:8] !== 8'd19) begin failures++; $display("FAIL ovf_lane1 got=%0d exp=19", outputs[15:8]); end
    checks++; if (ovf !== 2'b01) begin failures++; $display("FAIL ovf_flags got=%b exp=01", ovf); end
    a[0] = 1; b[0] = 1; vin = 1; clr = 1;
    tick();
    vin = 0; clr = 0;
    tick(); tick();
    checks++; if (outputs[7:0] !== 8'd1) begin failures++; $display("FAIL ovf_clear_lane0 got=%0d exp=1", outputs[7:0]); end
    checks++; if (ovf !== 2'b00) begin failures++; $display("FAIL ovf_clear_flags got=%b exp=00", ovf); end
  endtask
  task automatic test_flush();
    cfg(2'b01);
    a[0] = 2; b[0] = 3; a[1] = 0; b[1] = 0; vin = 1;
    tick();
    vin = 0;
    tick(); tick();
    checks++; if (outputs[7:0] !== 8'd6) begin failures++; $display("FAIL flush_pre got=%0d exp=6", outputs[7:0]); end
    a[0] = 4; vin = 1;
    tick();
    a[0] = 5;
    tick();
    vin = 0; cset = 1; conf = 2'b01;
    tick();
    cset = 0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (valid_out !== 1'b0 || outputs !== 16'h0 || ovf !== 2'b00) begin failures++; $display("FAIL flush_drop k=%0d got v=%b o=%h f=%b exp v=0 o=0000 f=00", k, valid_out, outputs, ovf); end
      tick();
    end
    cset = 1; conf = 2'b01; vin = 1; a[0] = 7; b[0] = 7;
    tick();
    cset = 0; vin = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL cset_discard k=%0d got=%b exp=0", k, valid_out); end
    end
  endtask
  task automatic test_lone_clr();
    cfg(2'b10);
    a[0] = 3; b[0] = 4; vin = 1; clr = 1;
    tick();
    a[0] = 5; b[0] = 5; clr = 0;
    tick();
    vin = 0;
    tick(); tick();
    checks++; if (outputs[7:0] !== 8'd37) begin failures++; $display("FAIL lone_clr_pre got=%0d exp=37", outputs[7:0]); end
    clr = 1;
    tick();
    clr = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL lone_clr_valid k=%0d got=%b exp=0", k, valid_out); end
      if (k == 1) begin
        checks++; if (outputs !== 16'h0 || ovf !== 2'b00) begin failures++; $display("FAIL lone_clr_result got o=%h f=%b exp o=0000 f=00", outputs, ovf); end
      end
    end
  endtask
  task automatic test_random();
    logic [15:0] eo;
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom % 300) == 0;
      cset = !rst && ($urandom % 150) == 0;
      conf = 2'($urandom);
      a[0] = 4'($urandom); b[0] = 4'($urandom); a[1] = 4'($urandom); b[1] = 4'($urandom);
      vin = ($urandom % 4) != 0;
      clr = (m_mode == 2'b10) ? (($urandom % 100) == 0) : 1'b0;
      tick();
      eo = {8'(m_out(1)), 8'(m_out(0))};
      checks++; if (outputs !== eo || valid_out !== m_valid || ovf !== {m_ovf[1], m_ovf[0]}) begin
        failures++;
        $display("FAIL random cyc=%0d got o=%h v=%b f=%b exp o=%h v=%b f=%b", k, outputs, valid_out, ovf, eo, m_valid, {m_ovf[1], m_ovf[0]});
      end
    end
    rst = 0; cset = 0; vin = 0; clr = 0;
  endtask
  initial begin
    test_reset();
    test_multiply();
    test_mac_stream();
    test_overflow();
    test_flush();
    test_lone_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
